// File: rtl/mem_arbiter_if.sv
// Bundles the fetch, load/store and physical-memory signals shared by mem_arbiter.
// slave is the arbiter's view; master is the surrounding core/memory view.
interface mem_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

   logic                  inst_read;
   logic [ADDR_WIDTH-1:0] inst_addr;
   logic                  inst_resp;
   logic [DATA_WIDTH-1:0] inst_rdata;

   logic                  data_read;
   logic                  data_write;
   logic [ADDR_WIDTH-1:0] data_addr;
   logic [DATA_WIDTH-1:0] data_wdata;
   logic [BE_WIDTH-1:0]   data_byte_enable;
   logic                  data_resp;
   logic [DATA_WIDTH-1:0] data_rdata;

   logic                  pmem_read;
   logic                  pmem_write;
   logic [ADDR_WIDTH-1:0] pmem_address;
   logic [DATA_WIDTH-1:0] pmem_wdata;
   logic [BE_WIDTH-1:0]   pmem_byte_enable;
   logic                  pmem_resp;
   logic [DATA_WIDTH-1:0] pmem_rdata;

   modport slave (
      input  inst_read, inst_addr,
      output inst_resp, inst_rdata,
      input  data_read, data_write, data_addr, data_wdata, data_byte_enable,
      output data_resp, data_rdata,
      output pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable,
      input  pmem_resp, pmem_rdata
   );

   modport master (
      output inst_read, inst_addr,
      input  inst_resp, inst_rdata,
      output data_read, data_write, data_addr, data_wdata, data_byte_enable,
      input  data_resp, data_rdata,
      input  pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_byte_enable,
      output pmem_resp, pmem_rdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one physical memory port between instruction fetch
// and load/store; the granted request is latched and held until pmem_resp.
module mem_arbiter #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) (
   input logic           clk,
   input logic           rst,
   mem_arbiter_if.slave  bus
);
   localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } state_e;

   typedef enum logic {
      GRANT_I = 1'b0,
      GRANT_D = 1'b1
   } grant_e;

   state_e                state_q, state_d;
   grant_e                last_grant_q, last_grant_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [BE_WIDTH-1:0]   be_q, be_d;
   logic                  read_q, read_d;
   logic                  write_q, write_d;

   logic inst_req;
   logic data_req;
   logic pick_inst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= GRANT_D;
         addr_q       <= '0;
         wdata_q      <= '0;
         be_q         <= '0;
         read_q       <= 1'b0;
         write_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         be_q         <= be_d;
         read_q       <= read_d;
         write_q      <= write_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      be_d         = be_q;
      read_d       = read_q;
      write_d      = write_q;
      inst_req     = bus.inst_read;
      data_req     = bus.data_read | bus.data_write;
      pick_inst    = 1'b0;

      unique case (state_q)
         IDLE: begin
            // On a tie the fetch wins only if data held the previous grant.
            pick_inst = inst_req && (!data_req || (last_grant_q == GRANT_D));
            if (pick_inst) begin
               state_d      = SERVE_I;
               last_grant_d = GRANT_I;
               addr_d       = bus.inst_addr;
               wdata_d      = '0;
               be_d         = '1;
               read_d       = 1'b1;
               write_d      = 1'b0;
            end else if (data_req) begin
               state_d      = SERVE_D;
               last_grant_d = GRANT_D;
               addr_d       = bus.data_addr;
               wdata_d      = bus.data_wdata;
               be_d         = bus.data_byte_enable;
               // Simultaneous read and write resolves to a write.
               read_d       = !bus.data_write;
               write_d      = bus.data_write;
            end
         end
         SERVE_I, SERVE_D: begin
            if (bus.pmem_resp) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.pmem_read        = (state_q != IDLE) && read_q;
   assign bus.pmem_write       = (state_q != IDLE) && write_q;
   assign bus.pmem_address     = addr_q;
   assign bus.pmem_wdata       = wdata_q;
   assign bus.pmem_byte_enable = be_q;

   assign bus.inst_resp  = (state_q == SERVE_I) && bus.pmem_resp;
   assign bus.data_resp  = (state_q == SERVE_D) && bus.pmem_resp;
   assign bus.inst_rdata = bus.pmem_rdata;
   assign bus.data_rdata = bus.pmem_rdata;

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(bus.data_read && bus.data_write));
      end
   end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port to one-port memory arbiter for the RV32I multicycle core. It shares the single physical memory interface between the instruction-fetch requester and the load/store requester. Requests are arbitrated round-robin, and the winning transaction is latched and held stable on the memory port until `pmem_resp`. The response is then routed back only to the requester that issued it. The block sits between the control/datapath pair and physical memory, and is the prerequisite for split I/D caches.

## Interface
- `ADDR_WIDTH`, default 32: address width for all ports.
- `DATA_WIDTH`, default 32: data width; byte-enable width is `DATA_WIDTH/8`.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `inst_read`  in  1  fetch request; held high until `inst_resp`.
- `inst_addr`  in  ADDR_WIDTH  fetch address.
- `inst_resp`  out  1  one-cycle completion pulse for the fetch.
- `inst_rdata`  out  DATA_WIDTH  fetch data, valid when `inst_resp`=1.
- `data_read`  in  1  load request; held high until `data_resp`.
- `data_write`  in  1  store request; held high until `data_resp`.
- `data_addr`  in  ADDR_WIDTH  load/store address.
- `data_wdata`  in  DATA_WIDTH  store data.
- `data_byte_enable`  in  DATA_WIDTH/8  store byte mask.
- `data_resp`  out  1  one-cycle completion pulse for the load/store.
- `data_rdata`  out  DATA_WIDTH  load data, valid when `data_resp`=1.
- `pmem_read`, `pmem_write`  out  1 each  physical memory strobes.
- `pmem_address`  out  ADDR_WIDTH  physical address.
- `pmem_wdata`  out  DATA_WIDTH  physical write data.
- `pmem_byte_enable`  out  DATA_WIDTH/8  physical byte mask.
- `pmem_resp`  in  1  memory completion, one cycle.
- `pmem_rdata`  in  DATA_WIDTH  memory read data, valid with `pmem_resp`.

## Operation

**FSM**
- States: IDLE, SERVE_I, SERVE_D. Reset state is IDLE.
- IDLE with only `inst_read` high: go to SERVE_I.
- IDLE with only `data_read` or `data_write` high: go to SERVE_D.
- IDLE with both requesters pending: grant the requester that was not granted last (`last_grant` register).
- `last_grant` resets to DATA, so an instruction fetch wins the first tie.
- The grant updates `last_grant`.

**Latching and memory drive**
- On grant, register the address, wdata, byte enable and op.
- A fetch latches op = read and byte enable = all ones.
- In SERVE_x, `pmem_*` are driven only from these registers. Requester inputs may change without affecting the memory port.

**Completion**
- In SERVE_x with `pmem_resp`=1: pulse `x_resp` in the same cycle (combinational from state & `pmem_resp`), then go to IDLE.
- Without `pmem_resp`, stay in SERVE_x.
- `inst_rdata` and `data_rdata` pass `pmem_rdata` through. They are meaningful only when the matching resp is high.
- A response is never forwarded to the non-granted requester.

**Boundary cases**
- `data_read` and `data_write` both high: treated as a write. A simulation assertion flags it.
- A requester drops its request mid-transaction: the transaction completes anyway, because memory cannot be aborted. The resp still pulses, and the requester ignores it.
- `pmem_resp` arriving in IDLE: ignored, no resp forwarded.
- `rst` mid-transaction: next state is IDLE, all `pmem_*` strobes deassert next cycle, and `last_grant` returns to DATA. The memory model is reset with the core.

**Reset values**
- `pmem_read`=0, `pmem_write`=0.
- `pmem_address`, `pmem_wdata` = 0; `pmem_byte_enable` = 0.
- `inst_resp`=0, `data_resp`=0.

## Timing
- Request first sampled high in IDLE at edge N: SERVE_x is entered and the `pmem` strobe is high in cycle N+1. This is one cycle of grant latency.
- `pmem_resp` high in cycle M: `x_resp` is high in cycle M; the state is IDLE and strobes are low in M+1.
- The next grant is sampled at end of M+1, so the earliest back-to-back strobe is M+2.
- Minimum transaction: 2 cycles arbitration overhead plus memory latency.
- Strobes never toggle within a transaction. `pmem_address`, `pmem_wdata` and `pmem_byte_enable` are constant from grant to `pmem_resp`.
- Round-robin bound: with both requesters continuously pending, grants strictly alternate I, D, I, D. No starvation.

## Test plan
- **Reset:** assert `rst` 2 cycles with random inputs. Then all `pmem` strobes are 0, both resps are 0, and the state is IDLE.
- **Single fetch:** `inst_read`=1, `inst_addr`=0x60 at cycle 1; memory responds with 0x00A00093 after 3 cycles. Then `pmem_read`=1 with `pmem_address`=0x60 and `pmem_byte_enable`=0xF from cycle 2; `inst_resp`=1 and `inst_rdata`=0x00A00093 for exactly one cycle; `data_resp` stays 0.
- **Store:** `data_write`=1, addr 0x100, wdata 0xDEADBEEF, mask 0x3. Then the `pmem` write carries exactly these values, and `data_resp` pulses once.
- **Tie after reset:** both requesters pending at the same cycle. Then the fetch is served first, then the data request. Across 4 sustained requests, the grant order is I, D, I, D.
- **Input change mid-transaction:** change `data_addr` 0x100→0x200 while SERVE_D is waiting. Then `pmem_address` stays 0x100 until `pmem_resp`.
- **Reset mid-transaction:** assert `rst` in SERVE_I before `pmem_resp`. Then strobes are low the next cycle, and `inst_resp` does not pulse even if `pmem_resp` arrives afterward.
